vote_round_ctrl: RTL and testbench
==================================

// Module: vote_round_ctrl
// PURPOSE
//  Sequences one voting round for the 3-input majority table: opens a collection window,
//  accepts one bit from each of three voters over valid/ready, applies majority (>=2 ones
//  -> 1) and returns the result over valid/ready. Sits between the voter sources and
//  the result consumer. Handles missing voters by timeout.
// PARAMETERS
//  TIMEOUT    16  max cycles spent in COLLECT before forcing a decision (>=1)
//  TIMER_W    5   width of collection timer; must hold TIMEOUT-1
//  ROUND_W    8   width of completed-round counter
// PORTS
//  clk           in   1        rising-edge clock
//  resetn        in   1        asynchronous active-low reset
//  start         in   1        begin a round; sampled only in IDLE
//  vote_valid    in   3        per-voter vote present
//  vote_bit      in   3        per-voter vote value
//  vote_ready    out  3        per-voter vote accepted this cycle when valid&ready
//  busy          out  1        state != IDLE
//  result_valid  out  1        result available (RESULT state)
//  result        out  1        majority decision
//  result_ready  in   1        consumer takes result
//  timed_out     out  1        last/current round closed by timeout
//  vote_mask     out  3        voters whose vote was captured this round
//  round_cnt     out  ROUND_W  completed rounds, wraps modulo 2^ROUND_W
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE; vote_ready=0, busy=0, result_valid=0, result=0,
//   timed_out=0, vote_mask=0, round_cnt=0, timer=0, latched votes=0. Reset mid-round
//   aborts it with no result and no round_cnt change.
//  FSM IDLE -> COLLECT -> DECIDE -> RESULT -> IDLE, all transitions registered.
//  IDLE: start=1 -> COLLECT; clears vote_mask, latched votes, timer, timed_out.
//  COLLECT: vote_ready[i] = ~vote_mask[i] (combinational from state/mask).
//   Handshake on voter i when vote_valid[i]&vote_ready[i]: latch vote_bit[i], set mask[i].
//   Any number of voters may handshake in the same cycle. vote_bit ignored without valid.
//   timer increments each COLLECT cycle.
//   Exit to DECIDE when mask (including this cycle's captures) == 3'b111, or when
//   timer == TIMEOUT-1. Timeout with mask incomplete after this cycle's captures sets
//   timed_out=1; a vote captured on the timeout cycle counts. Full mask on the timeout
//   cycle is not a timeout.
//  DECIDE (1 cycle): result <= majority of latched votes; uncaptured voters count as 0.
//   vote_ready=0.
//  RESULT: result_valid=1, result stable until result_ready=1; on handshake ->
//   IDLE, round_cnt++ (wraps), result_valid=0. result, timed_out, vote_mask hold
//   their values in IDLE until the next start.
//  start outside IDLE ignored. vote_valid outside COLLECT ignored (vote_ready=0).
//  Latency: start@T0; all votes valid@T1 -> accepted@T1, DECIDE@T2, result_valid@T3.
//  Worst case: result_valid at T0+TIMEOUT+2.
// TESTING
//  1 start@T0; votes valid@T1 with bits 3'b011 -> vote_ready 3'b111 @T1,
//    result_valid@T3, result=1, timed_out=0, vote_mask=3'b111.
//  2 staggered votes: v0=1@T1, v1=0@T3, v2=0@T5 -> vote_ready drops per voter after
//    capture; result=0 @T7; round_cnt 0->1 on handshake.
//  3 TIMEOUT=16, only v2=1 and v0=1 arrive -> decision after 16 COLLECT cycles,
//    timed_out=1, vote_mask=3'b101, result=1. Only v1=1 arrives -> result=0.
//  4 v1 arrives exactly on timer==TIMEOUT-1 completing mask -> timed_out=0, vote counted.
//  5 result_ready low 10 cycles -> result_valid/result held; start pulses during
//    rounds ignored; round_cnt wraps 255->0 after 256 rounds (ROUND_W=8).
//  6 resetn low mid-COLLECT with mask 3'b001 -> all outputs 0 immediately, IDLE;
//    next round starts clean with vote_mask=0.

Source files
------------

// File: rtl/vote_round_ctrl.sv
// vote_round_ctrl: sequences one 3-voter majority round.
// Flow: open a collection window, gather up to three votes over valid/ready,
// take the majority, then hand the result to the consumer over valid/ready.
// Voters that never show up are closed out by a collection timeout.
module vote_round_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TIMER_W = 5,
  parameter int ROUND_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [2:0]         vote_valid,
  input  logic [2:0]         vote_bit,
  output logic [2:0]         vote_ready,
  output logic               busy,
  output logic               result_valid,
  output logic               result,
  input  logic               result_ready,
  output logic               timed_out,
  output logic [2:0]         vote_mask,
  output logic [ROUND_W-1:0] round_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DECIDE  = 2'd2,
    S_RESULT  = 2'd3
  } state_t;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  // Majority of three: at least two ones.
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  state_t               state_r;
  state_t               state_s;
  logic [TIMER_W-1:0]   timer_r;
  logic [2:0]           votes_r;
  logic [2:0]           mask_r;
  logic                 result_r;
  logic                 timed_out_r;
  logic [ROUND_W-1:0]   round_cnt_r;

  logic [2:0]           vote_ready_s;
  logic                 busy_s;
  logic                 result_valid_s;
  logic [2:0]           capture_s;
  logic [2:0]           mask_next_s;
  logic                 timeout_hit_s;

  // Per-cycle capture terms shared by next-state and datapath logic.
  always_comb begin
    capture_s     = vote_valid & vote_ready_s;
    mask_next_s   = mask_r | capture_s;
    timeout_hit_s = (timer_r == TIMER_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decision.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_COLLECT;
        else       state_s = S_IDLE;
      end
      S_COLLECT: begin
        if ((mask_next_s == 3'b111) || timeout_hit_s) state_s = S_DECIDE;
        else                                          state_s = S_COLLECT;
      end
      S_DECIDE: state_s = S_RESULT;
      S_RESULT: begin
        if (result_ready) state_s = S_IDLE;
        else              state_s = S_RESULT;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register; ready only for voters not yet captured.
  always_comb begin
    vote_ready_s   = 3'b000;
    busy_s         = 1'b0;
    result_valid_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        vote_ready_s = 3'b000;
      end
      S_COLLECT: begin
        vote_ready_s = ~mask_r;
        busy_s       = 1'b1;
      end
      S_DECIDE: begin
        busy_s = 1'b1;
      end
      S_RESULT: begin
        busy_s         = 1'b1;
        result_valid_s = 1'b1;
      end
      default: begin
        vote_ready_s   = 3'b000;
        busy_s         = 1'b0;
        result_valid_s = 1'b0;
      end
    endcase
  end

  // Round datapath: timer, vote latches, mask, decision, timeout flag, round counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_r     <= {TIMER_W{1'b0}};
      votes_r     <= 3'b000;
      mask_r      <= 3'b000;
      result_r    <= 1'b0;
      timed_out_r <= 1'b0;
      round_cnt_r <= {ROUND_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            timer_r     <= {TIMER_W{1'b0}};
            votes_r     <= 3'b000;
            mask_r      <= 3'b000;
            timed_out_r <= 1'b0;
          end
        end
        S_COLLECT: begin
          timer_r <= timer_r + TIMER_W'(1);
          votes_r <= votes_r | (vote_bit & capture_s);
          mask_r  <= mask_next_s;
          // A vote landing on the last timer cycle still counts; only a short mask is a timeout.
          if (timeout_hit_s && (mask_next_s != 3'b111)) begin
            timed_out_r <= 1'b1;
          end
        end
        S_DECIDE: begin
          // Uncaptured voters were cleared to zero at round start, so they vote 0.
          result_r <= maj3(votes_r);
        end
        S_RESULT: begin
          if (result_ready) begin
            round_cnt_r <= round_cnt_r + ROUND_W'(1);
          end
        end
        default: begin
          timer_r <= {TIMER_W{1'b0}};
        end
      endcase
    end
  end

  assign vote_ready   = vote_ready_s;
  assign busy         = busy_s;
  assign result_valid = result_valid_s;
  assign result       = result_r;
  assign timed_out    = timed_out_r;
  assign vote_mask    = mask_r;
  assign round_cnt    = round_cnt_r;

endmodule

// File: tb/tb_vote_round_ctrl.sv
// Bench for vote_round_ctrl: directed rounds from the behaviour description plus
// randomized rounds, each checked against a per-round arrival-plan model.
module tb_vote_round_ctrl;

  localparam int TIMEOUT = 16;
  localparam int TIMER_W = 5;
  localparam int ROUND_W = 8;
  localparam int NEVER   = 1000;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               start = 1'b0;
  logic [2:0]         vote_valid = 3'b000;
  logic [2:0]         vote_bit = 3'b000;
  logic               result_ready = 1'b0;
  logic [2:0]         vote_ready;
  logic               busy;
  logic               result_valid;
  logic               result;
  logic               timed_out;
  logic [2:0]         vote_mask;
  logic [ROUND_W-1:0] round_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_rounds = 0;

  vote_round_ctrl #(
    .TIMEOUT(TIMEOUT),
    .TIMER_W(TIMER_W),
    .ROUND_W(ROUND_W)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .vote_valid(vote_valid),
    .vote_bit(vote_bit),
    .vote_ready(vote_ready),
    .busy(busy),
    .result_valid(result_valid),
    .result(result),
    .result_ready(result_ready),
    .timed_out(timed_out),
    .vote_mask(vote_mask),
    .round_cnt(round_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // One round. k* = COLLECT-cycle index at which each voter first offers its vote
  // (NEVER = not at all); bits = the values they offer; hold = cycles result_ready stays low.
  task automatic run_round(input int k0, input int k1, input int k2,
                           input logic [2:0] bits, input int hold);
    int         k [3];
    logic [2:0] mask;
    logic [2:0] exp_ready;
    logic [2:0] exp_mask;
    int         close;
    bit         all_in;
    logic       exp_res;
    logic       exp_to;
    k[0] = k0; k[1] = k1; k[2] = k2;
    // Reference: a voter is captured the cycle it offers if that lies inside the window.
    mask = 3'b000; close = 0; all_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (k[i] <= TIMEOUT - 1) begin
        mask[i] = 1'b1;
        if (k[i] > close) close = k[i];
      end else begin
        all_in = 1'b0;
      end
    end
    if (!all_in) close = TIMEOUT - 1;
    exp_res = ($countones(mask & bits) >= 2);
    exp_to  = (mask != 3'b111);

    // T0: start, with junk votes that must be ignored in IDLE.
    @(negedge clk);
    start      = 1'b1;
    vote_valid = 3'($urandom);
    vote_bit   = 3'($urandom);

    for (int j = 0; j <= close; j++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      exp_ready = 3'b000;
      exp_mask  = 3'b000;
      for (int i = 0; i < 3; i++) begin
        exp_ready[i] = (k[i] >= j);
        exp_mask[i]  = (k[i] < j);
      end
      check_eq("busy_collect", busy, 1'b1);
      check_eq("rvalid_collect", result_valid, 1'b0);
      check_eq("vote_ready_collect", vote_ready, exp_ready);
      check_eq("vote_mask_collect", vote_mask, exp_mask);
      for (int i = 0; i < 3; i++) begin
        if (k[i] == j) begin
          vote_valid[i] = 1'b1;
          vote_bit[i]   = bits[i];
        end else if (k[i] < j) begin
          vote_valid[i] = 1'($urandom_range(0, 1));
          vote_bit[i]   = 1'($urandom_range(0, 1));
        end else begin
          vote_valid[i] = 1'b0;
          vote_bit[i]   = 1'($urandom_range(0, 1));
        end
      end
    end

    // DECIDE
    @(negedge clk);
    vote_valid = 3'($urandom);
    vote_bit   = 3'($urandom);
    start      = 1'($urandom_range(0, 1));
    check_eq("busy_decide", busy, 1'b1);
    check_eq("rvalid_decide", result_valid, 1'b0);
    check_eq("vote_ready_decide", vote_ready, 3'b000);
    check_eq("vote_mask_decide", vote_mask, mask);

    // RESULT, held until result_ready
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      check_eq("rvalid_result", result_valid, 1'b1);
      check_eq("result", result, exp_res);
      check_eq("timed_out", timed_out, exp_to);
      check_eq("vote_mask_result", vote_mask, mask);
      check_eq("vote_ready_result", vote_ready, 3'b000);
      check_eq("round_cnt_result", round_cnt, exp_rounds % (1 << ROUND_W));
      result_ready = (h == hold);
      start        = 1'($urandom_range(0, 1));
      vote_valid   = 3'($urandom);
    end
    exp_rounds++;

    // Back in IDLE: decision fields hold, counter advanced.
    @(negedge clk);
    result_ready = 1'b0;
    start        = 1'b0;
    vote_valid   = 3'b000;
    check_eq("busy_idle", busy, 1'b0);
    check_eq("rvalid_idle", result_valid, 1'b0);
    check_eq("round_cnt_idle", round_cnt, exp_rounds % (1 << ROUND_W));
    check_eq("result_hold", result, exp_res);
    check_eq("timed_out_hold", timed_out, exp_to);
    check_eq("vote_mask_hold", vote_mask, mask);
  endtask

  // Reset asserted mid-COLLECT after voter 0 was captured.
  task automatic reset_mid_round();
    @(negedge clk);
    start      = 1'b1;
    vote_valid = 3'b000;
    @(negedge clk);
    start      = 1'b0;
    vote_valid = 3'b001;
    vote_bit   = 3'b001;
    @(negedge clk);
    vote_valid = 3'b000;
    check_eq("mask_before_reset", vote_mask, 3'b001);
    check_eq("ready_before_reset", vote_ready, 3'b110);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ready", vote_ready, 3'b000);
    check_eq("rst_rvalid", result_valid, 1'b0);
    check_eq("rst_result", result, 1'b0);
    check_eq("rst_timed_out", timed_out, 1'b0);
    check_eq("rst_mask", vote_mask, 3'b000);
    check_eq("rst_round_cnt", round_cnt, 0);
    exp_rounds = 0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int         kr [3];
    int         mode;
    logic [2:0] rbits;
    // Reset state
    #12;
    check_eq("init_busy", busy, 1'b0);
    check_eq("init_ready", vote_ready, 3'b000);
    check_eq("init_rvalid", result_valid, 1'b0);
    check_eq("init_result", result, 1'b0);
    check_eq("init_timed_out", timed_out, 1'b0);
    check_eq("init_mask", vote_mask, 3'b000);
    check_eq("init_round_cnt", round_cnt, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed rounds
    run_round(0, 0, 0, 3'b011, 0);                    // all at once, result 1
    run_round(0, 2, 4, 3'b001, 1);                    // staggered, result 0
    run_round(0, NEVER, 0, 3'b101, 0);                // timeout, mask 101, result 1
    run_round(NEVER, 0, NEVER, 3'b010, 0);            // timeout, lone 1 -> 0
    run_round(0, TIMEOUT - 1, 0, 3'b010, 0);          // completes on last cycle
    run_round(3, 1, 2, 3'b110, 10);                   // long consumer stall
    run_round(TIMEOUT, TIMEOUT + 1, 5, 3'b111, 2);    // late voters miss the window

    // Randomized rounds; enough of them to wrap the 8-bit round counter.
    for (int r = 0; r < 260; r++) begin
      mode  = $urandom_range(0, 2);
      rbits = 3'($urandom);
      for (int i = 0; i < 3; i++) begin
        if (mode == 0) kr[i] = $urandom_range(0, 4);
        else if ($urandom_range(0, 4) == 0) kr[i] = NEVER;
        else kr[i] = $urandom_range(0, TIMEOUT + 2);
      end
      run_round(kr[0], kr[1], kr[2], rbits, $urandom_range(0, 3));
    end

    reset_mid_round();
    run_round(1, 0, 2, 3'b100, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
